// File: rtl/iir_out_buffer.sv
// ----------------------------------------------------------------------------
// iir_out_buffer
//
// Elastic first-word-fall-through FIFO that sits behind iir_lookahead. Every
// sample qualified by VIN is written into a small circular buffer and then
// offered to the consumer with a valid/ready handshake. A stalled consumer
// loses no data until the buffer is full. After that, further samples are
// dropped and the sticky OVF flag is set.
//
// Parameters
//   NB     sample width (matches the filter output width)
//   DEPTH  number of entries; must be a power of two and >= 2
//   AW     pointer width, derived from DEPTH
//
// Ports
//   CLK      in   clock; all state changes on the rising edge
//   RST_n    in   asynchronous active-low reset; flushes all contents
//   DIN      in   sample from the filter
//   VIN      in   sample valid; one sample per high cycle
//   READY    in   consumer takes DOUT this cycle (only meaningful when VOUT=1)
//   CLR_OVF  in   synchronous clear of OVF (loses to a simultaneous set)
//   DOUT     out  head-of-FIFO sample (combinational read of registered array)
//   VOUT     out  DOUT valid, i.e. FIFO not empty
//   FULL     out  occupancy == DEPTH
//   EMPTY    out  occupancy == 0
//   CNT      out  occupancy, 0..DEPTH
//   OVF      out  sticky: a sample was dropped because the FIFO was full
// ----------------------------------------------------------------------------
module iir_out_buffer #(
    parameter int NB    = 12,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic [NB-1:0] DIN,
    input  logic          VIN,
    input  logic          READY,
    input  logic          CLR_OVF,
    output logic [NB-1:0] DOUT,
    output logic          VOUT,
    output logic          FULL,
    output logic          EMPTY,
    output logic [AW:0]   CNT,
    output logic          OVF
);

    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [NB-1:0] mem_q [DEPTH];
    logic [NB-1:0] mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic drop;

    // Status comes from the counter only. Pointer equality cannot tell full
    // from empty.
    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);

    assign pop  = !empty && READY;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = VIN && (!full || pop);
    assign drop = VIN && full && !pop;

    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;

        if (push) begin
            mem_d[wp_q] = DIN;
            wp_d        = wp_q + 1'b1;
        end

        if (pop) begin
            rp_d = rp_q + 1'b1;
        end

        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end

        // A drop in the same cycle as CLR_OVF must leave the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign DOUT  = mem_q[rp_q];
    assign VOUT  = !empty;
    assign FULL  = full;
    assign EMPTY = empty;
    assign CNT   = cnt_q;
    assign OVF   = ovf_q;

endmodule
